// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: digit scan, per-digit decimal point
// and blink, PWM brightness, and one dead cycle at the start of every digit slot.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [5*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp_en,
    input  logic [NUM_DIGITS-1:0]         blink_en,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_tick
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP  = REFRESH_DIV >> BRIGHT_W;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] DIGIT_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(BLINK_FRAMES - 1);

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'b0000001;
            5'd1:    g = 7'b1001111;
            5'd2:    g = 7'b0010010;
            5'd3:    g = 7'b0000110;
            5'd4:    g = 7'b1001100;
            5'd5:    g = 7'b0100100;
            5'd6:    g = 7'b0100000;
            5'd7:    g = 7'b0001111;
            5'd8:    g = 7'b0000000;
            5'd9:    g = 7'b0000100;
            5'd10:   g = 7'b0001000;
            5'd11:   g = 7'b1100000;
            5'd12:   g = 7'b0110001;
            5'd13:   g = 7'b1000010;
            5'd14:   g = 7'b0110000;
            5'd15:   g = 7'b0111000;
            5'd17:   g = 7'b1111110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0] slot_cnt, slot_nxt;
    logic [SEL_W-1:0] digit_cnt, digit_nxt;
    logic [FR_W-1:0]  frame_cnt, frame_nxt;
    logic             blink_phase, blink_phase_nxt;
    logic             tick_pend;
    logic             slot_wrap, frame_wrap, slot_start;

    always_comb begin
        slot_wrap       = (slot_cnt == SLOT_LAST);
        frame_wrap      = slot_wrap && (digit_cnt == DIGIT_LAST);
        slot_start      = (slot_cnt == '0);
        slot_nxt        = slot_wrap ? '0 : slot_cnt + 1'b1;
        digit_nxt       = digit_cnt;
        frame_nxt       = frame_cnt;
        blink_phase_nxt = blink_phase;
        if (slot_wrap) begin
            digit_nxt = (digit_cnt == DIGIT_LAST) ? '0 : digit_cnt + 1'b1;
        end
        if (frame_wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_nxt       = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                frame_nxt = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            digit_cnt   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            tick_pend   <= 1'b0;
        end else begin
            slot_cnt    <= slot_nxt;
            digit_cnt   <= digit_nxt;
            frame_cnt   <= frame_nxt;
            blink_phase <= blink_phase_nxt;
            tick_pend   <= frame_wrap;
        end
    end

    // Per-slot snapshot; the slot's first cycle uses the live inputs directly.
    logic [4:0]          digit_code [NUM_DIGITS];
    logic [4:0]          snap_code, eff_code;
    logic                snap_dp, eff_dp;
    logic                snap_blink, eff_blink;
    logic [BRIGHT_W-1:0] snap_bright, eff_bright;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_code
        assign digit_code[k] = digits[5*k +: 5];
    end

    always_comb begin
        eff_code   = slot_start ? digit_code[digit_cnt] : snap_code;
        eff_dp     = slot_start ? dp_en[digit_cnt]      : snap_dp;
        eff_blink  = slot_start ? blink_en[digit_cnt]   : snap_blink;
        eff_bright = slot_start ? brightness            : snap_bright;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_code   <= '0;
            snap_dp     <= 1'b0;
            snap_blink  <= 1'b0;
            snap_bright <= '0;
        end else if (slot_start) begin
            snap_code   <= eff_code;
            snap_dp     <= eff_dp;
            snap_blink  <= eff_blink;
            snap_bright <= eff_bright;
        end
    end

    logic [CNT_W:0]        on_limit;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        on_limit = (CNT_W+1)'((int'(eff_bright) + 1) * STEP);
        lit      = !slot_start && ({1'b0, slot_cnt} < on_limit) && !(blink_phase && eff_blink);
        an_nxt   = '1;
        if (lit) begin
            an_nxt[digit_cnt] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= decode(eff_code);
            dp         <= ~eff_dp;
            digit_sel  <= digit_cnt;
            frame_tick <= tick_pend;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle model feeding a scoreboard queue, plus scenario checks.
module tb_seg_scan_driver;
    localparam int N = 4, RD = 8, BW = 2, BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] digits;
    logic [3:0]  dp_en, blink_en;
    logic [1:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_W(BW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp_en(dp_en), .blink_en(blink_en),
        .brightness(brightness), .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       ft;
    } obs_t;

    localparam obs_t RST_OBS = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};

    obs_t sb_q[$];
    obs_t exp_now;
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'd0: g = 7'b0000001;  5'd1: g = 7'b1001111;  5'd2: g = 7'b0010010;
            5'd3: g = 7'b0000110;  5'd4: g = 7'b1001100;  5'd5: g = 7'b0100100;
            5'd6: g = 7'b0100000;  5'd7: g = 7'b0001111;  5'd8: g = 7'b0000000;
            5'd9: g = 7'b0000100;  5'd10: g = 7'b0001000; 5'd11: g = 7'b1100000;
            5'd12: g = 7'b0110001; 5'd13: g = 7'b1000010; 5'd14: g = 7'b0110000;
            5'd15: g = 7'b0111000; 5'd17: g = 7'b1111110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    function automatic obs_t observed();
        return {an, seg, dp, digit_sel, frame_tick};
    endfunction

    // Reference model: at each edge, predicts the registered outputs after that edge.
    int         m_slot = 0, m_dig = 0, m_frame = 0;
    bit         m_phase = 0, m_ft1 = 0;
    logic [4:0] s_code;
    logic       s_dp, s_blink;
    logic [1:0] s_br;

    always @(posedge clk) begin
        obs_t       e;
        logic [4:0] code;
        logic       dpb, bl;
        logic [1:0] br;
        bit         lit;
        if (rst) begin
            e = RST_OBS;
            m_slot <= 0; m_dig <= 0; m_frame <= 0; m_phase <= 0; m_ft1 <= 0;
        end else begin
            if (m_slot == 0) begin
                code = digits[5*m_dig +: 5]; dpb = dp_en[m_dig]; bl = blink_en[m_dig]; br = brightness;
                s_code <= code; s_dp <= dpb; s_blink <= bl; s_br <= br;
            end else begin
                code = s_code; dpb = s_dp; bl = s_blink; br = s_br;
            end
            lit = (m_slot >= 1) && (m_slot < (int'(br) + 1) * (RD >> BW)) && !(m_phase && bl);
            e.an = 4'hF;
            if (lit) e.an[m_dig] = 1'b0;
            e.seg = glyph(code);
            e.dp  = ~dpb;
            e.sel = 2'(m_dig);
            e.ft  = m_ft1;
            m_ft1 <= (m_slot == RD-1) && (m_dig == N-1);
            if (m_slot == RD-1) begin
                m_slot <= 0;
                if (m_dig == N-1) begin
                    m_dig <= 0;
                    if (m_frame == BF-1) begin m_frame <= 0; m_phase <= ~m_phase; end
                    else m_frame <= m_frame + 1;
                end else m_dig <= m_dig + 1;
            end else m_slot <= m_slot + 1;
        end
        sb_q.push_back(e);
    end

    task automatic next_cycle();
        @(negedge clk);
        if (sb_q.size() > 0) exp_now = sb_q.pop_front();
        else exp_now = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1; digits = {5'd3, 5'd2, 5'd1, 5'd0};
        dp_en = 4'b0; blink_en = 4'b0; brightness = 2'd3;
        repeat (3) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL reset_sb got=%h exp=%h", observed(), exp_now); end
            checks++;
            if (observed() !== RST_OBS) begin fails++; $display("FAIL reset_vals got=%h exp=%h", observed(), RST_OBS); end
        end
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        int sl, d;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL scan_sb i=%0d got=%h exp=%h", i, observed(), exp_now); end
            sl = i % 8; d = (i / 8) % 4;
            ea = (sl == 0) ? 4'hF : ~(4'b0001 << d);
            checks++;
            if (an !== ea || digit_sel !== 2'(d) || seg !== glyph(5'(d)) || frame_tick !== 1'((i % 32 == 0) && (i > 0))) begin
                fails++;
                $display("FAIL scan i=%0d got an=%b sel=%0d seg=%b ft=%b exp an=%b sel=%0d seg=%b", i, an, digit_sel, seg, frame_tick, ea, d, glyph(5'(d)));
            end
        end
    endtask

    task automatic test_brightness();
        int lows [4];
        bit seen;
        for (int b = 0; b < 2; b++) begin
            brightness = 2'(b);
            seen = 0;
            for (int w = 0; w < 40 && !seen; w++) begin
                next_cycle();
                checks++;
                if (observed() !== exp_now) begin fails++; $display("FAIL bright_sb got=%h exp=%h", observed(), exp_now); end
                seen = (frame_tick === 1'b1);
            end
            checks++;
            if (!seen) begin fails++; $display("FAIL bright_wait got=no_frame_tick exp=frame_tick"); end
            lows = '{default: 0};
            for (int j = 0; j < 32; j++) begin
                if (j > 0) begin
                    next_cycle();
                    checks++;
                    if (observed() !== exp_now) begin fails++; $display("FAIL bright_sb got=%h exp=%h", observed(), exp_now); end
                end
                for (int k = 0; k < 4; k++) if (an[k] === 1'b0) lows[k]++;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (lows[k] !== ((b == 0) ? 1 : 3)) begin
                    fails++; $display("FAIL bright_duty b=%0d digit=%0d got=%0d exp=%0d", b, k, lows[k], (b == 0) ? 1 : 3);
                end
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_glyphs();
        logic [4:0] codes [3];
        logic [6:0] exps  [3];
        bit seen;
        codes = '{5'd16, 5'd17, 5'd31};
        exps  = '{7'b1111111, 7'b1111110, 7'b1111111};
        dp_en = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            digits[14:10] = codes[c];
            seen = 0;
            for (int w = 0; w < 40 && !seen; w++) begin
                next_cycle();
                checks++;
                if (observed() !== exp_now) begin fails++; $display("FAIL glyph_sb got=%h exp=%h", observed(), exp_now); end
                seen = (frame_tick === 1'b1);
            end
            for (int j = 0; j < 32; j++) begin
                if (j > 0) begin
                    next_cycle();
                    checks++;
                    if (observed() !== exp_now) begin fails++; $display("FAIL glyph_sb got=%h exp=%h", observed(), exp_now); end
                end
                if (digit_sel === 2'd2) begin
                    checks++;
                    if (seg !== exps[c]) begin fails++; $display("FAIL glyph code=%0d got=%b exp=%b", codes[c], seg, exps[c]); end
                end
                checks++;
                if (dp !== (digit_sel !== 2'd2)) begin fails++; $display("FAIL dp sel=%0d got=%b exp=%b", digit_sel, dp, digit_sel !== 2'd2); end
            end
        end
        digits[14:10] = 5'd2;
        dp_en = 4'b0;
    endtask

    task automatic test_snapshot();
        bit seen, left;
        logic [6:0] es;
        digits = {5'd3, 5'd2, 5'd1, 5'd1};
        seen = 0;
        for (int w = 0; w < 80 && !seen; w++) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL snap_sb got=%h exp=%h", observed(), exp_now); end
            seen = (m_dig == 0) && (m_slot == 4) && (w > 8);
        end
        checks++;
        if (!seen) begin fails++; $display("FAIL snap_wait got=not_found exp=slot4_digit0"); end
        digits[4:0] = 5'd8;
        left = 0;
        for (int j = 0; j < 40; j++) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL snap_sb got=%h exp=%h", observed(), exp_now); end
            if (digit_sel !== 2'd0) left = 1;
            else begin
                es = left ? 7'b0000000 : 7'b1001111;
                checks++;
                if (seg !== es) begin fails++; $display("FAIL snapshot j=%0d got=%b exp=%b", j, seg, es); end
            end
        end
        digits[4:0] = 5'd0;
    endtask

    task automatic test_blink();
        int l0, l1, f;
        blink_en = 4'b0001;
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        l0 = 0; l1 = 0;
        for (int i = 0; i < 192; i++) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL blink_sb i=%0d got=%h exp=%h", i, observed(), exp_now); end
            checks++;
            if ($countones(~an) > 1) begin fails++; $display("FAIL onehot got=%b exp=at_most_one_low", an); end
            if (an[0] === 1'b0) l0++;
            if (an[1] === 1'b0) l1++;
            if (i % 32 == 31) begin
                f = i / 32;
                checks++;
                if (l0 !== ((f == 2 || f == 3) ? 0 : 7)) begin
                    fails++; $display("FAIL blink_d0 frame=%0d got=%0d exp=%0d", f, l0, (f == 2 || f == 3) ? 0 : 7);
                end
                checks++;
                if (l1 !== 7) begin fails++; $display("FAIL blink_d1 frame=%0d got=%0d exp=7", f, l1); end
                l0 = 0; l1 = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int l0;
        seen = 0;
        for (int w = 0; w < 40 && !seen; w++) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL rmid_sb got=%h exp=%h", observed(), exp_now); end
            seen = (m_dig == 2) && (m_slot == 3);
        end
        checks++;
        if (!seen) begin fails++; $display("FAIL rmid_wait got=not_found exp=digit2"); end
        rst = 1'b1;
        next_cycle();
        checks++;
        if (observed() !== RST_OBS) begin fails++; $display("FAIL rmid_vals got=%h exp=%h", observed(), RST_OBS); end
        rst = 1'b0;
        l0 = 0;
        for (int i = 0; i < 32; i++) begin
            next_cycle();
            checks++;
            if (observed() !== exp_now) begin fails++; $display("FAIL rmid_sb i=%0d got=%h exp=%h", i, observed(), exp_now); end
            checks++;
            if (digit_sel !== 2'(i / 8)) begin fails++; $display("FAIL rmid_sel i=%0d got=%0d exp=%0d", i, digit_sel, i / 8); end
            if (an[0] === 1'b0) l0++;
        end
        checks++;
        if (l0 !== 7) begin fails++; $display("FAIL rmid_blink_off got=%0d exp=7", l0); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_brightness();
        test_glyphs();
        test_snapshot();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule
